// File: rtl/life_run_ctrl.sv
// Run sequencer for the 8x8 Game-of-Life datapath: seeds the grid, steps generations and
// stops on extinction, still life, period-2 oscillation, generation limit or abort.
module life_run_ctrl #(
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             seed_sel,
    input  logic             step_mode,
    input  logic             step,
    input  logic [GEN_W-1:0] gen_limit,
    input  logic [63:0]      Grid_Evolved,
    output logic [1:0]       a,
    output logic             busy,
    output logic             done,
    output logic [2:0]       status,
    output logic [GEN_W-1:0] gen_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCapture,
        StEvolve,
        StCheck,
        StWaitStep,
        StDone
    } state_e;

    localparam logic [2:0] StatNone    = 3'b000;
    localparam logic [2:0] StatExtinct = 3'b001;
    localparam logic [2:0] StatStill   = 3'b010;
    localparam logic [2:0] StatPeriod2 = 3'b011;
    localparam logic [2:0] StatLimit   = 3'b100;
    localparam logic [2:0] StatAbort   = 3'b101;

    localparam logic [1:0] ModeLoadPreset = 2'b00;
    localparam logic [1:0] ModeEvolve     = 2'b01;
    localparam logic [1:0] ModeHold       = 2'b10;
    localparam logic [1:0] ModeLoadLfsr   = 2'b11;

    state_e           state_q;
    logic [63:0]      prev1_q;
    logic [63:0]      prev2_q;
    logic             prev2_valid_q;
    logic             seed_sel_q;
    logic [GEN_W-1:0] gen_limit_q;
    logic [2:0]       status_q;
    logic [GEN_W-1:0] gen_count_q;

    logic grid_zero;
    logic match_prev1;
    logic match_prev2;
    logic limit_hit;

    assign status    = status_q;
    assign gen_count = gen_count_q;

    // Moore decode; reset drives state to idle, so a returns to hold without a clock
    always_comb begin
        a    = ModeHold;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StLoad: begin
                a    = seed_sel_q ? ModeLoadLfsr : ModeLoadPreset;
                busy = 1'b1;
            end
            StEvolve: begin
                a    = ModeEvolve;
                busy = 1'b1;
            end
            StCapture, StCheck, StWaitStep: busy = 1'b1;
            StDone:                         done = 1'b1;
            default:                        ;
        endcase
    end

    always_comb begin
        grid_zero   = (Grid_Evolved == 64'd0);
        match_prev1 = (Grid_Evolved == prev1_q);
        match_prev2 = prev2_valid_q && (Grid_Evolved == prev2_q);
        limit_hit   = (gen_limit_q != '0) && (gen_count_q == gen_limit_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            prev1_q       <= '0;
            prev2_q       <= '0;
            prev2_valid_q <= 1'b0;
            seed_sel_q    <= 1'b0;
            gen_limit_q   <= '0;
            status_q      <= StatNone;
            gen_count_q   <= '0;
        end else if (busy && abort) begin
            state_q  <= StDone;
            status_q <= StatAbort;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        seed_sel_q    <= seed_sel;
                        gen_limit_q   <= gen_limit;
                        gen_count_q   <= '0;
                        status_q      <= StatNone;
                        prev2_valid_q <= 1'b0;
                        state_q       <= StLoad;
                    end
                end
                StLoad: state_q <= StCapture;
                StCapture: begin
                    prev1_q <= Grid_Evolved;
                    if (grid_zero) begin
                        status_q <= StatExtinct;
                        state_q  <= StDone;
                    end else begin
                        state_q <= step_mode ? StWaitStep : StEvolve;
                    end
                end
                StEvolve: begin
                    if (gen_count_q != '1) begin
                        gen_count_q <= gen_count_q + 1'b1;
                    end
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (grid_zero) begin
                        status_q <= StatExtinct;
                        state_q  <= StDone;
                    end else if (match_prev1) begin
                        status_q <= StatStill;
                        state_q  <= StDone;
                    end else if (match_prev2) begin
                        status_q <= StatPeriod2;
                        state_q  <= StDone;
                    end else if (limit_hit) begin
                        status_q <= StatLimit;
                        state_q  <= StDone;
                    end else begin
                        prev2_q       <= prev1_q;
                        prev1_q       <= Grid_Evolved;
                        prev2_valid_q <= 1'b1;
                        state_q       <= step_mode ? StWaitStep : StEvolve;
                    end
                end
                StWaitStep: begin
                    if (step || !step_mode) begin
                        state_q <= StEvolve;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_life_run_ctrl.sv
// Directed bench for life_run_ctrl with a behavioural 8x8 Life datapath driven by a.
module tb_life_run_ctrl;

    localparam int unsigned GEN_W = 16;

    localparam logic [63:0] GridSingle  = 64'h0000_0010_0000_0000;
    localparam logic [63:0] GridBlock   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] GridBlinker = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] GridGlider  = 64'h0000_001C_1008_0000;
    localparam logic [63:0] LfsrSeed    = 64'h0000_0018_1800_0000;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             seed_sel;
    logic             step_mode;
    logic             step;
    logic [GEN_W-1:0] gen_limit;
    logic [63:0]      grid;
    logic [63:0]      preset;
    logic [1:0]       a;
    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic [GEN_W-1:0] gen_count;

    int n_checks;
    int n_fail;
    int evo_cnt;

    life_run_ctrl #(.GEN_W(GEN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .seed_sel    (seed_sel),
        .step_mode   (step_mode),
        .step        (step),
        .gen_limit   (gen_limit),
        .Grid_Evolved(grid),
        .a           (a),
        .busy        (busy),
        .done        (done),
        .status      (status),
        .gen_count   (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] nx;
        nx = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8) begin
                            n += int'(g[(r + dr) * 8 + (c + dc)]);
                        end
                    end
                end
                nx[r * 8 + c] = (n == 3) || (g[r * 8 + c] && n == 2);
            end
        end
        return nx;
    endfunction

    // Datapath stand-in: acts on a at posedge, result visible in the following state
    always @(posedge clk) begin
        case (a)
            2'b00:   grid <= preset;
            2'b11:   grid <= LfsrSeed;
            2'b01:   grid <= life_next(grid);
            default: grid <= grid;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (a == 2'b01) evo_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [63:0] g, input logic sel, input logic [GEN_W-1:0] lim);
        preset    = g;
        seed_sel  = sel;
        gen_limit = lim;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        evo_cnt = 0;
    endtask

    task automatic run_to_done(input string tag);
        for (int i = 0; i < 40 && !done; i++) tick();
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        evo_cnt   = 0;
        grid      = '0;
        preset    = '0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        seed_sel  = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        gen_limit = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        check("rst_a", 64'(a), 64'h2);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_gen", 64'(gen_count), 64'd0);

        // Single cell: dies after one generation
        begin_run(GridSingle, 1'b0, 16'd0);
        check("single_a_load", 64'(a), 64'h0);
        check("single_busy", 64'(busy), 64'd1);
        tick();
        check("single_a_capture", 64'(a), 64'h2);
        tick();
        check("single_a_evolve", 64'(a), 64'h1);
        tick();
        check("single_a_check", 64'(a), 64'h2);
        check("single_done_early", 64'(done), 64'd0);
        tick();
        check("single_done", 64'(done), 64'd1);
        check("single_status", 64'(status), 64'd1);
        check("single_gen", 64'(gen_count), 64'd1);

        // Block: still life after one evolve
        begin_run(GridBlock, 1'b0, 16'd0);
        run_to_done("block");
        check("block_status", 64'(status), 64'd2);
        check("block_gen", 64'(gen_count), 64'd1);
        check("block_evolves", 64'(evo_cnt), 64'd1);

        // Blinker: period 2
        begin_run(GridBlinker, 1'b0, 16'd0);
        run_to_done("blinker");
        check("blinker_status", 64'(status), 64'd3);
        check("blinker_gen", 64'(gen_count), 64'd2);
        check("blinker_evolves", 64'(evo_cnt), 64'd2);

        // Glider with limit 3
        begin_run(GridGlider, 1'b0, 16'd3);
        run_to_done("glider");
        check("glider_status", 64'(status), 64'd4);
        check("glider_gen", 64'(gen_count), 64'd3);
        repeat (4) tick();
        check("glider_evolves", 64'(evo_cnt), 64'd3);
        check("glider_done_hold", 64'(done), 64'd1);

        // Single-step blinker
        step_mode = 1'b1;
        begin_run(GridBlinker, 1'b0, 16'd0);
        repeat (2) tick();
        repeat (5) tick();
        check("step_idle_a", 64'(a), 64'h2);
        check("step_idle_busy", 64'(busy), 64'd1);
        check("step_idle_evolves", 64'(evo_cnt), 64'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step1_a", 64'(a), 64'h1);
        repeat (6) tick();
        check("step1_evolves", 64'(evo_cnt), 64'd1);
        check("step1_busy", 64'(busy), 64'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("step2_done", 64'(done), 64'd1);
        check("step2_status", 64'(status), 64'd3);
        check("step2_evolves", 64'(evo_cnt), 64'd2);
        step_mode = 1'b0;

        // Abort mid free-run: LOAD, CAPTURE, EVOLVE, CHECK, EVOLVE(gen 1)
        begin_run(GridGlider, 1'b0, 16'd0);
        repeat (4) tick();
        check("abort_pre_a", 64'(a), 64'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_status", 64'(status), 64'd5);
        check("abort_done", 64'(done), 64'd1);
        check("abort_gen", 64'(gen_count), 64'd1);
        check("abort_a", 64'(a), 64'h2);
        evo_cnt = 0;
        repeat (5) tick();
        check("abort_no_evolve", 64'(evo_cnt), 64'd0);

        // Asynchronous reset during EVOLVE
        begin_run(GridGlider, 1'b0, 16'd0);
        repeat (4) tick();
        check("rstmid_pre_a", 64'(a), 64'h1);
        reset = 1'b1;
        #1;
        check("rstmid_a", 64'(a), 64'h2);
        check("rstmid_gen", 64'(gen_count), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        #1;
        reset = 1'b0;
        tick();
        check("rstmid_idle_a", 64'(a), 64'h2);
        check("rstmid_idle_done", 64'(done), 64'd0);

        // LFSR seed path
        begin_run(GridSingle, 1'b1, 16'd0);
        check("lfsr_a_load", 64'(a), 64'h3);
        run_to_done("lfsr");
        check("lfsr_status", 64'(status), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
